// File: rtl/lti_sample_driver.sv
`default_nettype none
// ============================================================================
//  Module   : lti_sample_driver
//  Purpose  : Initiator side of the clock-enable sample protocol for the
//             state-space filter blocks. Takes samples from upstream over
//             valid/ready and issues one to the filter every DIV clocks as a
//             one-cycle enable strobe plus data. Captures the filter result
//             on its completion strobe and presents it downstream over
//             valid/ready. Flags underrun, overrun and timeout conditions as
//             sticky errors.
//  Ports    : clk, rst (async, active-high)
//             in_data/in_valid/in_ready        upstream sample handshake
//             filt_ce/filt_in                  issue strobe and sample to filter
//             filt_out/filt_done               filter result and completion
//             out_data/out_valid/out_ready     downstream result handshake
//             err_clr                          clears the sticky error flags
//             err_underrun/err_overrun/err_timeout  sticky error flags
//             issue_cnt/drop_cnt               statistics counters (optional)
//  Options  : define LTI_SAMPLE_DRIVER_STATS_EN to add issue_cnt / drop_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module lti_sample_driver #(
   parameter int IW  = 16,
   parameter int OW  = 16,
   parameter int DIV = 100,
   parameter int TMO = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          filt_ce,
   output logic [IW-1:0] filt_in,
   input  logic [OW-1:0] filt_out,
   input  logic          filt_done,
   output logic [OW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   input  logic          err_clr,
   output logic          err_underrun,
   output logic          err_overrun,
   output logic          err_timeout
`ifdef LTI_SAMPLE_DRIVER_STATS_EN
   ,
   output logic [31:0]   issue_cnt,
   output logic [31:0]   drop_cnt
`endif
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_tmr_w = (TMO > 0) ? $clog2(TMO + 1) : 1;

   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
   localparam logic [c_tmr_w-1:0] c_tmo      = c_tmr_w'(TMO);

   // The response window has to close before the next period tick, otherwise
   // a tick could land while still waiting on the filter.
   generate
      if (DIV < TMO + 3) begin : g_param_check
         $error("lti_sample_driver: DIV (%0d) must be >= TMO+3 (%0d)", DIV, TMO + 3);
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------------
   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_div_w-1:0] r_div_cnt;
   logic [c_tmr_w-1:0] r_timer;
   logic               r_hold_valid;
   logic [IW-1:0]      r_hold_data;

   logic               w_tick;
   logic               w_accept;
   logic               w_issue;
   logic               w_underrun;
   logic               w_capture;
   logic               w_timeout;
   logic               w_overrun;

   assign w_tick   = (r_div_cnt == c_div_last);
   // in_ready is held low while rst is asserted so every output reads 0.
   assign in_ready = ~r_hold_valid & ~rst;
   assign w_accept = in_valid & in_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and event decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_underrun  = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // filt_done seen here is stale or spurious and is dropped.
            if (w_tick) begin
               w_issue     = 1'b1;
               w_underrun  = ~r_hold_valid;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Completion takes priority over a timeout in the same cycle.
            if (filt_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_timer == c_tmo) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // A capture overwrites an unread result unless that result leaves in the
   // same cycle.
   assign w_overrun = w_capture & out_valid & ~out_ready;

   // ------------------------------------------------------------------------
   // Divider, timer and hold register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt    <= '0;
         r_timer      <= '0;
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
      end else begin
         r_div_cnt <= w_tick ? '0 : r_div_cnt + c_div_w'(1);

         if (w_issue) begin
            r_timer <= '0;
         end else if ((r_state == S_WAIT) && (r_timer != c_tmo)) begin
            r_timer <= r_timer + c_tmr_w'(1);
         end

         // An accept can only coincide with an issue when the register was
         // empty (underrun reissue), so load and clear never collide.
         if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= in_data;
         end else if (w_issue && r_hold_valid) begin
            r_hold_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Filter interface, result register and sticky errors
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_ce      <= 1'b0;
         filt_in      <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         err_underrun <= 1'b0;
         err_overrun  <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         filt_ce <= w_issue;
         // On underrun filt_in keeps the last sample so it is reissued.
         if (w_issue && r_hold_valid) begin
            filt_in <= r_hold_data;
         end

         if (w_capture) begin
            out_data  <= filt_out;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // Setting an error wins over a clear in the same cycle.
         err_underrun <= w_underrun | (err_underrun & ~err_clr);
         err_overrun  <= w_overrun  | (err_overrun  & ~err_clr);
         err_timeout  <= w_timeout  | (err_timeout  & ~err_clr);
      end
   end

`ifdef LTI_SAMPLE_DRIVER_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics: an event in the clear cycle counts from zero.
   // ------------------------------------------------------------------------
   logic        w_drop;
   logic [31:0] w_issue_base;
   logic [31:0] w_drop_base;
   logic [31:0] w_issue_nxt;
   logic [31:0] w_drop_nxt;

   always_comb begin
      w_drop       = w_underrun | w_overrun | w_timeout;
      w_issue_base = err_clr ? 32'd0 : issue_cnt;
      w_drop_base  = err_clr ? 32'd0 : drop_cnt;
      w_issue_nxt  = w_issue_base + {31'd0, w_issue};
      w_drop_nxt   = w_drop_base;
      if (w_drop && (w_drop_base != 32'hFFFF_FFFF)) begin
         w_drop_nxt = w_drop_base + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         issue_cnt <= w_issue_nxt;
         drop_cnt  <= w_drop_nxt;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lti_sample_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lti_sample_driver
//  Purpose  : Self-checking bench for lti_sample_driver. A reference model
//             tracks the expected issue stream, result stream and error flags
//             from the period arithmetic; a separate monitor pops and compares
//             whenever the DUT strobes the filter or hands over a result.
//  Ports    : none
//  Options  : LTI_SAMPLE_DRIVER_STATS_EN also checks issue_cnt / drop_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lti_sample_driver;

   localparam int IW  = 16;
   localparam int OW  = 16;
   localparam int DIV = 10;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          filt_ce;
   logic [IW-1:0] filt_in;
   logic [OW-1:0] filt_out = '0;
   logic          filt_done = 1'b0;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          err_clr = 1'b0;
   logic          err_underrun;
   logic          err_overrun;
   logic          err_timeout;
`ifdef LTI_SAMPLE_DRIVER_STATS_EN
   logic [31:0]   issue_cnt;
   logic [31:0]   drop_cnt;
`endif

   always #5 clk = ~clk;

   lti_sample_driver #(.IW(IW), .OW(OW), .DIV(DIV), .TMO(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .filt_ce      (filt_ce),
      .filt_in      (filt_in),
      .filt_out     (filt_out),
      .filt_done    (filt_done),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .err_clr      (err_clr),
      .err_underrun (err_underrun),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout)
`ifdef LTI_SAMPLE_DRIVER_STATS_EN
      ,
      .issue_cnt    (issue_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------------
   int            cyc;              // clock edges since reset release
   bit            m_hold_valid;
   logic [IW-1:0] m_hold_data;
   logic [IW-1:0] m_last;           // last sample handed to the filter
   bit            m_busy;           // an issued sample awaits completion
   int            m_issue_cyc;      // cycle in which the strobe is visible
   bit            m_out_valid;
   bit            m_accepted;
   bit            m_eu, m_eo, m_et;
   logic [31:0]   m_icnt, m_dcnt;
   logic [IW-1:0] issue_q[$];
   logic [OW-1:0] out_q[$];

   // Inputs driven during the current cycle
   bit            p_in_valid, p_filt_done, p_out_ready, p_err_clr;
   logic [IW-1:0] p_in_data;
   logic [OW-1:0] p_filt_out;

   // Stimulus controls
   int            ph_in_pct, ph_ready_pct, ph_dmin, ph_dmax, ph_never_pct, ph_clr_pct;
   bit            ph_first;
   logic [IW-1:0] ph_first_val;
   bit            ph_fix_out;
   logic [OW-1:0] ph_out_val;
   bit            force_clr;
   int            done_at;

   task automatic set_phase(input int in_pct, input int rdy, input int dmin,
                            input int dmax, input int never, input int clr);
      ph_in_pct = in_pct; ph_ready_pct = rdy; ph_dmin = dmin;
      ph_dmax = dmax; ph_never_pct = never; ph_clr_pct = clr;
   endtask

   task automatic model_reset();
      cyc = 0; m_hold_valid = 0; m_hold_data = '0; m_last = '0;
      m_busy = 0; m_issue_cyc = 0; m_out_valid = 0; m_accepted = 0;
      m_eu = 0; m_eo = 0; m_et = 0; m_icnt = '0; m_dcnt = '0;
      issue_q.delete(); out_q.delete();
      p_in_valid = 0; p_filt_done = 0; p_out_ready = 0; p_err_clr = 0;
      p_in_data = '0; p_filt_out = '0; done_at = -1;
   endtask

   // Advance the model across one clock edge using the inputs of the cycle
   // that just ended.
   task automatic model_edge();
      bit tick, issue, und, ovr, tmo, cap;
      logic [IW-1:0] v;
      tick = ((cyc % DIV) == DIV - 1);
      issue = 0; und = 0; ovr = 0; tmo = 0; cap = 0;
      m_accepted = p_in_valid && !m_hold_valid;
      if (m_busy) begin
         if (p_filt_done) cap = 1;
         else if (cyc - m_issue_cyc == TMO) tmo = 1;
         if (cap || tmo) m_busy = 0;
      end else if (tick) begin
         issue = 1;
         if (m_hold_valid) begin
            v = m_hold_data; m_hold_valid = 0;
         end else begin
            v = m_last; und = 1;
         end
         m_last = v;
         issue_q.push_back(v);
         m_busy = 1;
         m_issue_cyc = cyc + 1;
      end
      if (m_accepted) begin
         m_hold_valid = 1; m_hold_data = p_in_data;
      end
      if (cap) begin
         ovr = m_out_valid && !p_out_ready;
         if (ovr && out_q.size() > 0) void'(out_q.pop_back());
         out_q.push_back(p_filt_out);
         m_out_valid = 1;
      end else if (m_out_valid && p_out_ready) begin
         m_out_valid = 0;
      end
      m_eu = und | (m_eu & !p_err_clr);
      m_eo = ovr | (m_eo & !p_err_clr);
      m_et = tmo | (m_et & !p_err_clr);
      if (p_err_clr) begin m_icnt = '0; m_dcnt = '0; end
      if (issue) m_icnt = m_icnt + 32'd1;
      if ((und || ovr || tmo) && m_dcnt != 32'hFFFF_FFFF) m_dcnt = m_dcnt + 32'd1;
      cyc++;
   endtask

   // Choose and apply this cycle's inputs; the bench also plays the filter.
   task automatic drive_inputs();
      if (!(p_in_valid && !m_accepted)) begin
         p_in_valid = ($urandom_range(99) < ph_in_pct);
         p_in_data  = IW'($urandom);
         if (ph_first) begin
            p_in_valid = 1; p_in_data = ph_first_val; ph_first = 0;
         end
      end
      if (filt_ce) begin
         if ($urandom_range(99) < ph_never_pct) done_at = -1;
         else done_at = cyc + int'($urandom_range(ph_dmax, ph_dmin));
      end
      p_filt_done = (cyc == done_at);
      p_filt_out  = ph_fix_out ? ph_out_val : OW'($urandom);
      p_out_ready = ($urandom_range(99) < ph_ready_pct);
      p_err_clr   = force_clr || ($urandom_range(99) < ph_clr_pct);
      force_clr   = 0;
      in_valid  = p_in_valid;  in_data  = p_in_data;
      filt_done = p_filt_done; filt_out = p_filt_out;
      out_ready = p_out_ready; err_clr  = p_err_clr;
   endtask

   task automatic step();
      @(posedge clk); #1;
      model_edge();
      drive_inputs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " filt_ce"},      filt_ce,      1'b0);
      check({tag, " filt_in"},      filt_in,      '0);
      check({tag, " out_data"},     out_data,     '0);
      check({tag, " out_valid"},    out_valid,    1'b0);
      check({tag, " in_ready"},     in_ready,     1'b0);
      check({tag, " err_underrun"}, err_underrun, 1'b0);
      check({tag, " err_overrun"},  err_overrun,  1'b0);
      check({tag, " err_timeout"},  err_timeout,  1'b0);
`ifdef LTI_SAMPLE_DRIVER_STATS_EN
      check({tag, " issue_cnt"},    issue_cnt,    '0);
      check({tag, " drop_cnt"},     drop_cnt,     '0);
`endif
   endtask

   task automatic release_reset();
      rst = 0;
      model_reset();
      drive_inputs();
      #1 check("in_ready after release", in_ready, 1'b1);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: compares whatever the DUT presents against the scoreboard
   // ------------------------------------------------------------------------
   logic [IW-1:0] exp_in;
   logic [OW-1:0] exp_out;

   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", in_ready, !m_hold_valid);
         if (filt_ce) begin
            if (issue_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL filt_ce: got unexpected strobe, filt_in %0h, required none at %0t", filt_in, $time);
            end else begin
               exp_in = issue_q.pop_front();
               check("filt_in", filt_in, exp_in);
            end
         end else if (issue_q.size() != 0) begin
            exp_in = issue_q.pop_front();
            checks++; errors++;
            $display("FAIL filt_ce: got no strobe, required strobe with %0h at %0t", exp_in, $time);
         end
         check("out_valid", out_valid, m_out_valid);
         if (out_valid && out_ready) begin
            if (out_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_data: got unexpected result %0h, required none at %0t", out_data, $time);
            end else begin
               exp_out = out_q.pop_front();
               check("out_data", out_data, exp_out);
            end
         end
         check("err_underrun", err_underrun, m_eu);
         check("err_overrun",  err_overrun,  m_eo);
         check("err_timeout",  err_timeout,  m_et);
`ifdef LTI_SAMPLE_DRIVER_STATS_EN
         check("issue_cnt", issue_cnt, m_icnt);
         check("drop_cnt",  drop_cnt,  m_dcnt);
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus sequence
   // ------------------------------------------------------------------------
   initial begin
      int n;
      model_reset();
      force_clr = 0; ph_first = 0; ph_fix_out = 0;
      ph_first_val = '0; ph_out_val = '0;
      set_phase(0, 100, 2, 2, 0, 0);

      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(posedge clk); #1;
      ph_first = 1; ph_first_val = 16'h1234;
      ph_fix_out = 1; ph_out_val = 16'h0ABC;
      release_reset();

      // One sample, filter answers two clocks after the strobe.
      repeat (16) step();

      // No samples: reissue of the last sample with underrun, then clear.
      ph_fix_out = 0;
      repeat (2 * DIV + 2) step();
      force_clr = 1;
      repeat (3) step();

      // Downstream stalled across several completions, then drained.
      set_phase(100, 0, 2, 2, 0, 0);
      repeat (3 * DIV) step();
      set_phase(100, 100, 2, 2, 0, 0);
      repeat (DIV) step();
      force_clr = 1;

      // Filter never answers, then answers too late.
      set_phase(100, 100, 0, 0, 100, 0);
      repeat (2 * DIV) step();
      set_phase(100, 100, TMO + 1, TMO + 2, 0, 0);
      repeat (2 * DIV) step();
      force_clr = 1;
      step();

      // Reset while waiting on the filter.
      set_phase(100, 100, 0, 0, 100, 0);
      n = 0;
      while (!filt_ce && n < 3 * DIV) begin step(); n++; end
      check("reached issue before reset", filt_ce, 1'b1);
      step();
      rst = 1;
      #1 check_all_zero("async reset");
      in_valid = 0; filt_done = 0; out_ready = 0; err_clr = 0;
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      set_phase(100, 100, 2, 2, 0, 0);
      release_reset();
      repeat (3 * DIV) step();

      // Random mix.
      set_phase(60, 70, 0, TMO + 2, 10, 3);
      repeat (1500) step();

      // Drain and confirm nothing is left outstanding.
      set_phase(0, 100, 1, 1, 0, 0);
      repeat (3 * DIV) step();
      @(negedge clk); #1;
      check("issue queue drained", 64'(issue_q.size()), 64'd0);
      check("result queue drained", 64'(out_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
